// File: rtl/muldiv_hilo_if.sv
// E-stage mult/div control, mthi/mtlo writes and HI/LO/stall/done returns for muldiv_hilo.
interface muldiv_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancelE;
    logic             hiwriteM;
    logic             lowriteM;
    logic [WIDTH-1:0] wdataM;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output startE, opE, srcaE, srcbE, cancelE, hiwriteM, lowriteM, wdataM,
        input  stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, cancelE, hiwriteM, lowriteM, wdataM,
        output stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative signed/unsigned multiply/divide unit with the HI/LO register pair.
// Optional MULDIV_EARLY_OUT_EN: zero divisor or zero multiplicand commits on the accepting edge.
module muldiv_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_hilo_if.slave mdBus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Calc = 2'd1,
        Done = 2'd2
    } stateType;

    stateType state, stateNext;

    logic [CntW-1:0]  counter;
    logic [WIDTH-1:0] absA, absB, origA;
    logic [WIDTH-1:0] accHi, accLo;
    logic             isDiv, negRes, negRem, divZero;
    logic [WIDTH-1:0] hiQ, loQ;

    logic             accept, earlyOut, commitCalc, commitEarly;
    logic             isSignedIn;
    logic [WIDTH-1:0] absAIn, absBIn;
    logic             stallOut, doneOut;

    // Operand magnitudes taken at acceptance; unsigned ops pass through.
    assign isSignedIn = ~mdBus.opE[0];
    assign absAIn = (isSignedIn && mdBus.srcaE[WIDTH-1]) ? -mdBus.srcaE : mdBus.srcaE;
    assign absBIn = (isSignedIn && mdBus.srcbE[WIDTH-1]) ? -mdBus.srcbE : mdBus.srcbE;

    assign accept      = (state == Idle) && mdBus.startE && !mdBus.cancelE;
    assign commitCalc  = (state == Calc) && !mdBus.cancelE && (counter == LastCnt);
    assign commitEarly = accept && earlyOut;

`ifdef MULDIV_EARLY_OUT_EN
    assign earlyOut = (mdBus.srcbE == '0) || (!mdBus.opE[1] && (mdBus.srcaE == '0));
`else
    assign earlyOut = 1'b0;
`endif

    // One shift-add or restoring-subtract step on the shared {accHi, accLo} pair.
    logic [WIDTH:0]   mulSum, divTrial;
    logic [WIDTH-1:0] stepHi, stepLo;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, absA} : '0);
        divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, absB};
        stepHi   = accHi;
        stepLo   = accLo;
        if (isDiv) begin
            stepHi = divTrial[WIDTH] ? {accHi[WIDTH-2:0], accLo[WIDTH-1]} : divTrial[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};
        end else begin
            {stepHi, stepLo} = {mulSum, accLo[WIDTH-1:1]};
        end
    end

    // Sign correction of the final step and divide-by-zero override.
    logic [2*WIDTH-1:0] prodMag, prodFix;
    logic [WIDTH-1:0]   resHi, resLo;

    always_comb begin
        prodMag = {stepHi, stepLo};
        prodFix = negRes ? -prodMag : prodMag;
        if (!isDiv) begin
            {resHi, resLo} = prodFix;
        end else if (divZero) begin
            resHi = origA;
            resLo = '1;
        end else begin
            resHi = negRem ? -stepHi : stepHi;
            resLo = negRes ? -stepLo : stepLo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= Idle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            Idle:    if (accept) stateNext = earlyOut ? Done : Calc;
            Calc:    if (mdBus.cancelE) stateNext = Idle;
                     else if (counter == LastCnt) stateNext = Done;
            Done:    stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    // Idle stall is combinational so the E stage holds during the start cycle.
    always_comb begin
        stallOut = 1'b0;
        doneOut  = 1'b0;
        case (state)
            Idle:    stallOut = mdBus.startE && !mdBus.cancelE;
            Calc:    stallOut = 1'b1;
            Done:    doneOut  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
            absA    <= '0;
            absB    <= '0;
            origA   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
        end else if (accept) begin
            counter <= '0;
            absA    <= absAIn;
            absB    <= absBIn;
            origA   <= mdBus.srcaE;
            accHi   <= '0;
            accLo   <= mdBus.opE[1] ? absAIn : absBIn;
            isDiv   <= mdBus.opE[1];
            negRes  <= isSignedIn && (mdBus.srcaE[WIDTH-1] ^ mdBus.srcbE[WIDTH-1]);
            negRem  <= isSignedIn && mdBus.opE[1] && mdBus.srcaE[WIDTH-1];
            divZero <= (mdBus.srcbE == '0);
        end else if (state == Calc) begin
            counter <= counter + CntW'(1);
            accHi   <= stepHi;
            accLo   <= stepLo;
        end
    end

    // A mult/div commit is younger than any concurrent mthi/mtlo and wins both registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hiQ <= '0;
            loQ <= '0;
        end else if (commitCalc) begin
            hiQ <= resHi;
            loQ <= resLo;
        end else if (commitEarly) begin
            hiQ <= mdBus.opE[1] ? mdBus.srcaE : '0;
            loQ <= mdBus.opE[1] ? '1 : '0;
        end else begin
            if (mdBus.hiwriteM) hiQ <= mdBus.wdataM;
            if (mdBus.lowriteM) loQ <= mdBus.wdataM;
        end
    end

    assign mdBus.stall_o = stallOut;
    assign mdBus.done_o  = doneOut;
    assign mdBus.hi_o    = hiQ;
    assign mdBus.lo_o    = loQ;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized self-checking bench for muldiv_hilo against an arithmetic HI/LO model.
module tb_muldiv_hilo;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(W)) mdBus ();
    muldiv_hilo #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mdBus(mdBus));

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} straight from integer arithmetic.
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, m;
        longint unsigned ua, ub, uq, um;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r  = '0;
        case (op)
            2'b00: r = 64'(sa * sb);
            2'b01: r = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    um = ua % ub;
                    r = {um[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    function automatic bit isEarly(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        return (b == 32'd0) || (!op[1] && a == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural model: phase, remaining iteration cycles, pending result, HI/LO.
    typedef enum {MIdle, MCalc, MDone} mPhaseType;
    mPhaseType   mPhase;
    int          mLeft;
    logic [31:0] mHi, mLo;
    logic [63:0] mPend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase = MIdle;
            mLeft  = 0;
            mHi    = '0;
            mLo    = '0;
        end else begin
            if (mdBus.hiwriteM) mHi = mdBus.wdataM;
            if (mdBus.lowriteM) mLo = mdBus.wdataM;
            case (mPhase)
                MIdle: if (mdBus.startE && !mdBus.cancelE) begin
                    mPend = refResult(mdBus.opE, mdBus.srcaE, mdBus.srcbE);
                    if (isEarly(mdBus.opE, mdBus.srcaE, mdBus.srcbE)) begin
                        {mHi, mLo} = mPend;
                        mPhase = MDone;
                    end else begin
                        mLeft  = W;
                        mPhase = MCalc;
                    end
                end
                MCalc: begin
                    mLeft--;
                    if (mdBus.cancelE) begin
                        mPhase = MIdle;
                    end else if (mLeft == 0) begin
                        {mHi, mLo} = mPend;
                        mPhase = MDone;
                    end
                end
                default: mPhase = MIdle;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("hi_o", 64'(mdBus.hi_o), 64'(mHi));
            chk("lo_o", 64'(mdBus.lo_o), 64'(mLo));
            chk("done_o", 64'(mdBus.done_o), 64'(mPhase == MDone));
            chk("stall_o", 64'(mdBus.stall_o),
                64'((mPhase == MCalc) || (mPhase == MIdle && mdBus.startE && !mdBus.cancelE)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and hold startE until DONE (returns in the DONE cycle) or cancel.
    task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancelAt, input int wrAt, input logic wrHi, input logic wrLo,
                        input logic [31:0] wd, output int stallCnt);
        int  n;
        bit  fin;
        n   = 0;
        fin = 1'b0;
        mdBus.startE  = 1'b1;
        mdBus.opE     = op;
        mdBus.srcaE   = a;
        mdBus.srcbE   = b;
        mdBus.cancelE = 1'b0;
        stallCnt      = 0;
        #1;
        if (mdBus.stall_o) stallCnt++;
        while (n < 40) begin
            cyc();
            n++;
            mdBus.hiwriteM = 1'b0;
            mdBus.lowriteM = 1'b0;
            if (mdBus.done_o) begin
                fin = 1'b1;
                break;
            end
            if (mdBus.stall_o) stallCnt++;
            if (n == cancelAt) begin
                mdBus.cancelE = 1'b1;
                cyc();
                mdBus.cancelE = 1'b0;
                mdBus.startE  = 1'b0;
                return;
            end
            if (n == wrAt) begin
                mdBus.hiwriteM = wrHi;
                mdBus.lowriteM = wrLo;
                mdBus.wdataM   = wd;
            end
        end
        if (!fin) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Leave DONE with startE still high, then drop it in the following Idle cycle.
    task automatic endOp();
        cyc();
        mdBus.startE = 1'b0;
        #1;
        chk("post_done_done", 64'(mdBus.done_o), 64'd0);
        chk("post_done_stall", 64'(mdBus.stall_o), 64'd0);
    endtask

    task automatic expectHiLo(input string name, input logic [31:0] hiExp, input logic [31:0] loExp);
        chk({name, "_hi"}, 64'(mdBus.hi_o), 64'(hiExp));
        chk({name, "_lo"}, 64'(mdBus.lo_o), 64'(loExp));
        chk({name, "_model_hi"}, 64'(mHi), 64'(hiExp));
        chk({name, "_model_lo"}, 64'(mLo), 64'(loExp));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    int sc;
    int fullStall;

    initial begin
        rst = 1'b0;
        mdBus.startE = 1'b0; mdBus.opE = '0; mdBus.srcaE = '0; mdBus.srcbE = '0;
        mdBus.cancelE = 1'b0; mdBus.hiwriteM = 1'b0; mdBus.lowriteM = 1'b0; mdBus.wdataM = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(mdBus.hi_o), 64'd0);
        chk("reset_lo", 64'(mdBus.lo_o), 64'd0);
        chk("reset_stall", 64'(mdBus.stall_o), 64'd0);
        chk("reset_done", 64'(mdBus.done_o), 64'd0);
        rst = 1'b1;
        cyc();

        doOp(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0, 1'b0, '0, sc);
        chk("mult_stall", 64'(sc), 64'd33);
        expectHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        endOp();

        doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, '0, sc);
        expectHiLo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        endOp();

        doOp(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 1'b0, '0, sc);
        expectHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        endOp();

        doOp(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 1'b0, '0, sc);
        expectHiLo("divu", 32'h0000_0001, 32'h7FFF_FFFC);
        endOp();

        doOp(2'b11, 32'd5, 32'd0, 0, 0, 1'b0, 1'b0, '0, sc);
`ifdef MULDIV_EARLY_OUT_EN
        chk("divz_stall", 64'(sc), 64'd1);
`else
        chk("divz_stall", 64'(sc), 64'd33);
`endif
        expectHiLo("divu_zero", 32'd5, 32'hFFFF_FFFF);
        endOp();

        doOp(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0, 1'b0, 1'b0, '0, sc);
        expectHiLo("div_zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        endOp();

        doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, '0, sc);
        expectHiLo("div_ovf", 32'd0, 32'h8000_0000);
        endOp();

        // mthi lands on the commit edge of a 0x10000 * 0x10000 multiply.
        doOp(2'b01, 32'h0001_0000, 32'h0001_0000, 0, 32, 1'b1, 1'b0, 32'h1234, sc);
        expectHiLo("mthi_vs_commit", 32'd1, 32'd0);
        endOp();

        doOp(2'b00, 32'd7, 32'd9, 10, 0, 1'b0, 1'b0, '0, sc);
        #1;
        expectHiLo("cancel", 32'd1, 32'd0);
        chk("cancel_done", 64'(mdBus.done_o), 64'd0);

        // Back-to-back: second op issued in the Idle cycle right after DONE.
        doOp(2'b01, 32'd6, 32'd7, 0, 0, 1'b0, 1'b0, '0, sc);
        cyc();
        doOp(2'b00, 32'd100, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, '0, sc);
        chk("b2b_stall", 64'(sc), 64'd33);
        expectHiLo("b2b", 32'hFFFF_FFFF, 32'hFFFF_FF9C);
        endOp();

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          cAt, wAt;
            op  = 2'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            cAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 32)) : 0;
            wAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
            doOp(op, a, b, cAt, wAt, 1'($urandom), 1'($urandom), 32'($urandom), sc);
            if (cAt == 0 && !isEarly(op, a, b)) begin
                fullStall = sc;
                chk("rand_stall", 64'(fullStall), 64'd33);
            end
            if (cAt == 0 || isEarly(op, a, b)) begin
                cyc();
                if ($urandom_range(0, 1) == 0) continue;
                mdBus.startE = 1'b0;
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                mdBus.hiwriteM = 1'($urandom);
                mdBus.lowriteM = 1'($urandom);
                mdBus.wdataM   = 32'($urandom);
                mdBus.startE   = 1'($urandom);
                mdBus.cancelE  = mdBus.startE;
                cyc();
                mdBus.hiwriteM = 1'b0;
                mdBus.lowriteM = 1'b0;
                mdBus.startE   = 1'b0;
                mdBus.cancelE  = 1'b0;
            end
        end

        // Asynchronous reset in the middle of an iteration.
        mdBus.startE = 1'b0;
        mdBus.hiwriteM = 1'b1; mdBus.lowriteM = 1'b1; mdBus.wdataM = 32'hDEAD_BEEF;
        cyc();
        mdBus.hiwriteM = 1'b0; mdBus.lowriteM = 1'b0;
        mdBus.startE = 1'b1; mdBus.opE = 2'b00; mdBus.srcaE = 32'd3; mdBus.srcbE = 32'd5;
        repeat (6) cyc();
        #2;
        mdBus.startE = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_hi", 64'(mdBus.hi_o), 64'd0);
        chk("async_rst_lo", 64'(mdBus.lo_o), 64'd0);
        chk("async_rst_stall", 64'(mdBus.stall_o), 64'd0);
        chk("async_rst_done", 64'(mdBus.done_o), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst_stall", 64'(mdBus.stall_o), 64'd0);
        doOp(2'b11, 32'd20, 32'd6, 0, 0, 1'b0, 1'b0, '0, sc);
        expectHiLo("post_rst_divu", 32'd2, 32'd3);
        endOp();
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
